reg_dump_streamer: RTL and testbench
====================================

# reg_dump_streamer

Reads the register file one register at a time and streams its contents as bytes over a valid/ready interface. It sits between the register bank's read side and a byte-oriented debug sink (UART TX, test-bench monitor) and drives the register read address itself. It is the reader-side counterpart of the register bank's write path and the serialized replacement for the parallel dump bus.

## Interface
Parameters:
- NUM_REGS, 32: number of registers dumped, r0..r(NUM_REGS-1); range 1..32.
- BYTES_PER_WORD, 4: bytes per register word; fixed at 4 for 32-bit data.

Ports:
- clock  in  1  system clock; the block has one clock and all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- rd_addr  out  5  register read address, driven to the register bank's read port.
- rd_data  in  32  combinational read data returned for rd_addr.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the byte when out_valid && out_ready at a rising edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final byte has been accepted.

## Operation
- The FSM has five states: IDLE, LOAD, SEND, CKSUM, DONE.
- IDLE: start=1 clears idx to 0, byte_cnt to 0 and cksum to 8'h00, then moves to LOAD. start is ignored in every other state.
- LOAD: rd_addr=idx. rd_data is captured into a 32-bit shift register at the end of the cycle. Next state is SEND.
- SEND: out_valid=1 and out_data=shift[31:24]; bytes go out MSB first.
  - On handshake: shift <<= 8, cksum ^= out_data, byte_cnt++.
  - After the 4th byte of a word, if idx==NUM_REGS-1 go to CKSUM (macro defined) or DONE (macro undefined). Otherwise idx++ and go to LOAD.
- CKSUM: out_valid=1 and out_data=cksum. On handshake go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Each word is sampled in its own LOAD cycle. A register written mid-dump appears with its new value only if the write lands before that register's LOAD cycle.
- rd_addr is 5 bits; idx never exceeds NUM_REGS-1. rd_addr=0 outside LOAD.
- Total bytes per dump: 4*NUM_REGS, plus 1 with the checksum.

## Timing
- Reset values: out_valid=0, out_data=8'h00, rd_addr=0, busy=0, done=0, state=IDLE.
- start is sampled at edge t. LOAD occupies cycle t+1, and the first out_valid is in cycle t+2.
- With out_ready held high, each word takes 5 cycles (1 LOAD + 4 SEND). A full 32-register dump is 160 cycles from the first LOAD to the last byte, plus 1 cycle for the checksum, plus 1 DONE cycle.
- Once raised, out_valid stays high and out_data stays stable until the handshake. out_valid never depends combinationally on out_ready.
- out_ready is don't-care when out_valid=0.
- Reset asserted mid-dump: outputs go to their reset values immediately (asynchronously), the stream is truncated, and no done pulse is produced.
- start asserted in the same cycle as done is ignored; the block reaches IDLE only on the following cycle.

## Configuration
- DUMP_CHECKSUM_EN defined: CKSUM state is present. One trailing byte is sent, equal to the XOR of all data bytes in the dump.
- DUMP_CHECKSUM_EN undefined: the CKSUM state and the cksum register are removed. The FSM goes from the last SEND to DONE, and the stream is exactly 4*NUM_REGS bytes.

## Structure
- Package reg_dump_pkg holds:
  - the state enum (IDLE, LOAD, SEND, CKSUM, DONE);
  - BYTES_PER_WORD=4;
  - CKSUM_INIT=8'h00;
  - REG_ADDR_W=5.
- Sub-module word_byte_serializer: a 32-bit load/shift register with a 2-bit byte counter. It has load, shift and last_byte outputs. The FSM, idx counter and checksum stay in the top level.

## Test plan
- Basic stream: r1=32'h11223344, r31=32'hDEADBEEF, all others 0, start with out_ready=1. Expect 128 bytes. Bytes 4..7 are 11,22,33,44; bytes 124..127 are DE,AD,BE,EF; the rest are 00. done pulses 1 cycle after the last handshake. The first out_valid appears 2 cycles after start.
- Backpressure: same data, with out_ready toggled pseudo-randomly and held low for 10 cycles mid-word. out_data must stay stable while stalled, the byte sequence must be identical to the basic stream, and no bytes may be lost or duplicated.
- Start while busy: pulse start again at byte 50. Expect no restart, exactly one done, and a byte count of 128.
- Reset mid-dump: assert reset at byte 70. Expect out_valid and busy to drop in the same cycle and no done. A new start after reset deasserts must yield a complete, correct 128-byte stream.
- Checksum (DUMP_CHECKSUM_EN): basic-stream data. Expect 129 bytes with the final byte 8'h66. With the macro undefined, expect 128 bytes and the last byte 8'hEF.
- Live update: write r5=32'hCAFEF00D before r5's LOAD, then r2=32'h1 after r2's LOAD. The stream must show CAFEF00D for r5 and the old value 0 for r2.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register dump streamer.
package reg_dump_pkg;

  // Dump sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned BYTE_CNT_W     = 2;
  localparam int unsigned REG_ADDR_W     = 5;

  localparam logic [BYTE_W-1:0] CKSUM_INIT = 8'h00;

endpackage

// File: rtl/reg_dump_streamer_word_byte_serializer.sv
// Word-to-byte serializer: loads a 32-bit word and shifts it out MSB first,
// flagging the final byte of the word.
module word_byte_serializer
  import reg_dump_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data_in,
  output logic [BYTE_W-1:0] byte_hi,
  output logic [BYTE_W-1:0] byte_nx,
  output logic              last_byte
);

  localparam logic [BYTE_CNT_W-1:0] CNT_PENULT = BYTE_CNT_W'(BYTES_PER_WORD - 2);

  logic [WORD_W-1:0]     shreg;
  logic [BYTE_CNT_W-1:0] cnt;

  // Load/shift register and byte position within the word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      cnt       <= '0;
      last_byte <= 1'b0;
    end else if (load) begin
      shreg     <= data_in;
      cnt       <= '0;
      last_byte <= 1'b0;
    end else if (shift) begin
      shreg     <= {shreg[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
      cnt       <= cnt + BYTE_CNT_W'(1);
      last_byte <= (cnt == CNT_PENULT);
    end
  end

  assign byte_hi = shreg[WORD_W-1 -: BYTE_W];
  assign byte_nx = shreg[WORD_W-BYTE_W-1 -: BYTE_W];

endmodule

// File: rtl/reg_dump_streamer.sv
// Streams registers r0..r(NUM_REGS-1) as bytes (MSB first) over valid/ready,
// driving the register bank read address itself.
// Optional feature macro: DUMP_CHECKSUM_EN appends an XOR checksum byte.
module reg_dump_streamer #(
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned BYTES_PER_WORD = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  output logic [reg_dump_pkg::REG_ADDR_W-1:0]  rd_addr,
  input  logic [8*BYTES_PER_WORD-1:0]          rd_data,
  output logic [7:0]                           out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 done
);

  import reg_dump_pkg::state_e;
  import reg_dump_pkg::IDLE;
  import reg_dump_pkg::LOAD;
  import reg_dump_pkg::SEND;
  import reg_dump_pkg::DONE;
  import reg_dump_pkg::REG_ADDR_W;
`ifdef DUMP_CHECKSUM_EN
  import reg_dump_pkg::CKSUM;
  import reg_dump_pkg::CKSUM_INIT;
`endif

  localparam int unsigned       WORD_W   = 8 * BYTES_PER_WORD;
  localparam logic [REG_ADDR_W-1:0] IDX_LAST = REG_ADDR_W'(NUM_REGS - 1);

  state_e                  state, state_next;
  logic [REG_ADDR_W-1:0]   idx, idx_next, rd_addr_next;
  logic [7:0]              out_data_next, byte_hi, byte_nx;
  logic                    out_valid_next, busy_next, done_next;
  logic                    load, shift_en, last_byte, hs;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]              cksum, cksum_next;
`endif

  assign hs = out_valid & out_ready;

  word_byte_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .shift     (shift_en),
    .data_in   (rd_data),
    .byte_hi   (byte_hi),
    .byte_nx   (byte_nx),
    .last_byte (last_byte)
  );

  // State, index and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      rd_addr   <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      rd_addr   <= rd_addr_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // Running XOR of every data byte accepted in this dump
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cksum <= CKSUM_INIT;
    else       cksum <= cksum_next;
  end
`endif

  // Next-state logic; outputs are derived from the upcoming state so they register cleanly
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    load           = 1'b0;
    shift_en       = 1'b0;
    rd_addr_next   = '0;
    out_valid_next = 1'b0;
    out_data_next  = 8'h00;
`ifdef DUMP_CHECKSUM_EN
    cksum_next     = cksum;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          idx_next   = '0;
`ifdef DUMP_CHECKSUM_EN
          cksum_next = CKSUM_INIT;
`endif
          state_next = LOAD;
        end
      end
      LOAD: begin
        load       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (hs) begin
          shift_en   = 1'b1;
`ifdef DUMP_CHECKSUM_EN
          cksum_next = cksum ^ out_data;
`endif
          if (last_byte) begin
            if (idx == IDX_LAST) begin
`ifdef DUMP_CHECKSUM_EN
              state_next = CKSUM;
`else
              state_next = DONE;
`endif
            end else begin
              idx_next   = idx + REG_ADDR_W'(1);
              state_next = LOAD;
            end
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CKSUM: begin
        if (hs) state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    case (state_next)
      LOAD: rd_addr_next = idx_next;
      SEND: begin
        out_valid_next = 1'b1;
        if (load)          out_data_next = rd_data[WORD_W-1 -: 8];
        else if (shift_en) out_data_next = byte_nx;
        else               out_data_next = byte_hi;
      end
`ifdef DUMP_CHECKSUM_EN
      CKSUM: begin
        out_valid_next = 1'b1;
        out_data_next  = cksum_next;
      end
`endif
      default: ;
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed testbench for reg_dump_streamer (optionally built with DUMP_CHECKSUM_EN).
module tb_reg_dump_streamer;

`ifdef DUMP_CHECKSUM_EN
  localparam int EXP_LEN = 129;
`else
  localparam int EXP_LEN = 128;
`endif

  logic        clock = 1'b0;
  logic        reset, start, out_ready;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  out_data;
  logic        out_valid, busy, done;

  logic [31:0] regs      [32];
  logic [31:0] exp_words [32];
  logic [7:0]  got [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -1;
  int ready_mode = 0, stall_left = 0;
  bit stall_done = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always #5 clock = ~clock;

  assign rd_data = regs[rd_addr];

  reg_dump_streamer #(.NUM_REGS(32), .BYTES_PER_WORD(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Stream monitor: collects accepted bytes, done pulses, and checks stall stability
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (prev_valid && !prev_ready) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_valid = out_valid & ~reset;
    prev_ready = out_ready;
    prev_data  = out_data;
  end

  // Sink ready driver: always-ready or pseudo-random with one long mid-word stall
  always @(negedge clock) begin
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    if (ready_mode == 0) out_ready = 1'b1;
    else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (!stall_done && got.size() == 22) begin
      out_ready  = 1'b0;
      stall_left = 9;
      stall_done = 1'b1;
    end else out_ready = lfsr[0];
  end

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = exp_words[i >> 2];
    return w[31 - 8*(i % 4) -: 8];
  endfunction

  task automatic load_basic();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1]  = 32'h11223344;
    regs[31] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) exp_words[i] = regs[i];
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    last_hs_cyc = -1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", out_data); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", rd_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_stream();
    bit ok;
    load_basic();
    clear_mon();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_load_busy: got %b, required 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_load_valid: got %b, required 0", out_valid); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL basic_load_addr: got %0d, required 0", rd_addr); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got %b, required 1", out_valid); end
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done, required done"); end
    checks++; if (got.size() != EXP_LEN) begin errors++; $display("FAIL basic_len: got %0d, required %0d", got.size(), EXP_LEN); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d, required 1", done_cnt); end
    checks++; if (done_cyc != last_hs_cyc + 1) begin errors++; $display("FAIL basic_done_lat: got %0d, required %0d", done_cyc, last_hs_cyc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b, required 0", busy); end
    if (got.size() >= 128) begin
      for (int i = 0; i < 128; i++) begin
        checks++;
        if (got[i] !== exp_byte(i)) begin errors++; $display("FAIL basic_byte[%0d]: got %h, required %h", i, got[i], exp_byte(i)); end
      end
`ifdef DUMP_CHECKSUM_EN
      checks++; if (got[got.size()-1] !== 8'h66) begin errors++; $display("FAIL basic_cksum: got %h, required 66", got[got.size()-1]); end
`else
      checks++; if (got[got.size()-1] !== 8'hEF) begin errors++; $display("FAIL basic_last: got %h, required EF", got[got.size()-1]); end
`endif
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    load_basic();
    clear_mon();
    stall_done = 1'b0;
    ready_mode = 1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(4000, ok);
    ready_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: got no done, required done"); end
    checks++; if (stall_done !== 1'b1) begin errors++; $display("FAIL bp_stall_seen: got %b, required 1", stall_done); end
    checks++; if (got.size() != EXP_LEN) begin errors++; $display("FAIL bp_len: got %0d, required %0d", got.size(), EXP_LEN); end
    if (got.size() >= 128) begin
      for (int i = 0; i < 128; i++) begin
        checks++;
        if (got[i] !== exp_byte(i)) begin errors++; $display("FAIL bp_byte[%0d]: got %h, required %h", i, got[i], exp_byte(i)); end
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    load_basic();
    clear_mon();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_bytes(50, 500, ok);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL swb_done_timeout: got no done, required done"); end
    repeat (10) @(negedge clock);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL swb_done_cnt: got %0d, required 1", done_cnt); end
    checks++; if (got.size() != EXP_LEN) begin errors++; $display("FAIL swb_len: got %0d, required %0d", got.size(), EXP_LEN); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    load_basic();
    clear_mon();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_done_timeout: got no done, required done"); end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done: busy got %b, required 0", busy); end
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stay_idle: busy got %b, required 0", busy); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_cnt: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_basic();
    clear_mon();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_bytes(70, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach70: got %0d bytes, required 70", got.size()); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b, required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL rst_mid_addr: got %0d, required 0", rd_addr); end
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d, required 0", done_cnt); end
    clear_mon();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_restart_timeout: got no done, required done"); end
    checks++; if (got.size() != EXP_LEN) begin errors++; $display("FAIL rst_restart_len: got %0d, required %0d", got.size(), EXP_LEN); end
    if (got.size() >= 128) begin
      for (int i = 0; i < 128; i++) begin
        checks++;
        if (got[i] !== exp_byte(i)) begin errors++; $display("FAIL rst_restart_byte[%0d]: got %h, required %h", i, got[i], exp_byte(i)); end
      end
    end
  endtask

  task automatic test_live_update();
    bit ok;
    load_basic();
    exp_words[5] = 32'hCAFEF00D;
    clear_mon();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_bytes(9, 500, ok);
    regs[2] = 32'h00000001;
    regs[5] = 32'hCAFEF00D;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL live_done_timeout: got no done, required done"); end
    checks++; if (got.size() != EXP_LEN) begin errors++; $display("FAIL live_len: got %0d, required %0d", got.size(), EXP_LEN); end
    if (got.size() >= 128) begin
      for (int i = 0; i < 128; i++) begin
        checks++;
        if (got[i] !== exp_byte(i)) begin errors++; $display("FAIL live_byte[%0d]: got %h, required %h", i, got[i], exp_byte(i)); end
      end
`ifdef DUMP_CHECKSUM_EN
      checks++; if (got[got.size()-1] !== 8'hAF) begin errors++; $display("FAIL live_cksum: got %h, required AF", got[got.size()-1]); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_live_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
